// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers (PC, IF/ID, ID/EX). Each cycle they apply the
// stall/flush decisions from hazard detection and keep saturating stall/flush/bubble counters.
module pipe_front_regs #(
  parameter int unsigned        XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = '0,
  parameter int unsigned        BUNDLE_W = 64,
  parameter int unsigned        CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_PC,
  input  logic                write_IFID,
  input  logic                flush_IFID,
  input  logic                flush_IDEX,
  input  logic [XLEN-1:0]     npc,
  input  logic [31:0]         instr_IF,
  input  logic [BUNDLE_W-1:0] bundle_ID,
  input  logic                cnt_clr,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     PC_IFID,
  output logic [31:0]         instr_IFID,
  output logic                valid_IFID,
  output logic [XLEN-1:0]     PC_IDEX,
  output logic [BUNDLE_W-1:0] bundle_IDEX,
  output logic                valid_IDEX,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic stall_c;
  assign stall_c = ~write_PC & ~write_IFID;

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      PC <= RESET_PC;
    end else if (write_PC) begin
      PC <= npc;
    end
  end

  // IF/ID register: a flush beats a hold
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_IFID    <= '0;
      instr_IFID <= NOP_INSTR;
      valid_IFID <= 1'b0;
    end else if (flush_IFID) begin
      PC_IFID    <= '0;
      instr_IFID <= NOP_INSTR;
      valid_IFID <= 1'b0;
    end else if (write_IFID) begin
      PC_IFID    <= PC;
      instr_IFID <= instr_IF;
      valid_IFID <= 1'b1;
    end
  end

  // ID/EX register advances every cycle; an all-zero bundle decodes as a harmless bubble
  always_ff @(posedge clk) begin
    if (rst || flush_IDEX) begin
      PC_IDEX     <= '0;
      bundle_IDEX <= '0;
      valid_IDEX  <= 1'b0;
    end else begin
      PC_IDEX     <= PC_IFID;
      bundle_IDEX <= bundle_ID;
      valid_IDEX  <= valid_IFID;
    end
  end

  // Saturating performance counters; clear takes priority over increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_c && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_IFID && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
      if (flush_IDEX && bubble_cnt != CNT_MAX) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them once the edge has passed.
module tb_pipe_front_regs;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BUNDLE_W = 64;
  localparam int unsigned CNT_W    = 4;

  localparam int S_PC = 0, S_PCIFID = 1, S_INSTR = 2, S_VIFID = 3, S_PCIDEX = 4;
  localparam int S_BUNDLE = 5, S_VIDEX = 6, S_STALL = 7, S_FLUSH = 8, S_BUBBLE = 9;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                write_PC = 1'b0, write_IFID = 1'b0, flush_IFID = 1'b0, flush_IDEX = 1'b0;
  logic [XLEN-1:0]     npc = '0;
  logic [31:0]         instr_IF = '0;
  logic [BUNDLE_W-1:0] bundle_ID = '0;
  logic                cnt_clr = 1'b0;
  logic [XLEN-1:0]     PC, PC_IFID, PC_IDEX;
  logic [31:0]         instr_IFID;
  logic                valid_IFID, valid_IDEX;
  logic [BUNDLE_W-1:0] bundle_IDEX;
  logic [CNT_W-1:0]    stall_cnt, flush_cnt, bubble_cnt;

  pipe_front_regs #(
    .XLEN(XLEN), .RESET_PC(32'h0000_0000), .BUNDLE_W(BUNDLE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .write_PC(write_PC), .write_IFID(write_IFID),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .npc(npc), .instr_IF(instr_IF), .bundle_ID(bundle_ID), .cnt_clr(cnt_clr),
    .PC(PC), .PC_IFID(PC_IFID), .instr_IFID(instr_IFID), .valid_IFID(valid_IFID),
    .PC_IDEX(PC_IDEX), .bundle_IDEX(bundle_IDEX), .valid_IDEX(valid_IDEX),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t        sbq[$];
  exp_t        ent;
  int unsigned cyc = 0;
  int          applied = 0;
  int          miscompares = 0;
  logic [63:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] field(input int sel);
    case (sel)
      S_PC:     return 64'(PC);
      S_PCIFID: return 64'(PC_IFID);
      S_INSTR:  return 64'(instr_IFID);
      S_VIFID:  return 64'(valid_IFID);
      S_PCIDEX: return 64'(PC_IDEX);
      S_BUNDLE: return bundle_IDEX;
      S_VIDEX:  return 64'(valid_IDEX);
      S_STALL:  return 64'(stall_cnt);
      S_FLUSH:  return 64'(flush_cnt);
      S_BUBBLE: return 64'(bubble_cnt);
      default:  return 64'hX;
    endcase
  endfunction

  function automatic string fname(input int sel);
    case (sel)
      S_PC: return "PC";               S_PCIFID: return "PC_IFID";
      S_INSTR: return "instr_IFID";    S_VIFID: return "valid_IFID";
      S_PCIDEX: return "PC_IDEX";      S_BUNDLE: return "bundle_IDEX";
      S_VIDEX: return "valid_IDEX";    S_STALL: return "stall_cnt";
      S_FLUSH: return "flush_cnt";     S_BUBBLE: return "bubble_cnt";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: outputs are stable at negedge; check every expectation due by now
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      ent = sbq.pop_front();
      act = field(ent.sel);
      applied++;
      if (act !== ent.exp) begin
        miscompares++;
        $display("FAIL %s @cycle %0d: got %h, expected %h", fname(ent.sel), cyc, act, ent.exp);
      end
    end
  end

  task automatic drive(input logic r, wp, wi, fi, fx, clr,
                       input logic [31:0] n, ins, input logic [63:0] b);
    @(negedge clk);
    rst = r; write_PC = wp; write_IFID = wi; flush_IFID = fi; flush_IDEX = fx;
    cnt_clr = clr; npc = n; instr_IF = ins; bundle_ID = b;
  endtask

  task automatic expect_next(input int sel, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc + 1;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic stall_step();
    drive(0, 0, 0, 0, 1, 0, 32'h0000_0FF0, 32'hFFFF_FFFF, 64'hBAD);
  endtask

  initial begin
    // Reset for two cycles, with every enable active to show reset wins
    drive(1, 1, 1, 1, 1, 0, 32'h999, 32'hFFFF_FFFF, 64'hDEAD);
    drive(1, 1, 1, 0, 0, 0, 32'h999, 32'hFFFF_FFFF, 64'hDEAD);
    expect_next(S_PC, 0);     expect_next(S_INSTR, 64'h13); expect_next(S_VIFID, 0);
    expect_next(S_VIDEX, 0);  expect_next(S_PCIFID, 0);     expect_next(S_PCIDEX, 0);
    expect_next(S_BUNDLE, 0); expect_next(S_STALL, 0);      expect_next(S_FLUSH, 0);
    expect_next(S_BUBBLE, 0);

    // Straight-line flow
    drive(0, 1, 1, 0, 0, 0, 32'h4, 32'h0010_0093, 64'hA0);
    expect_next(S_PC, 32'h4); expect_next(S_INSTR, 32'h0010_0093);
    expect_next(S_PCIFID, 0); expect_next(S_VIFID, 1); expect_next(S_VIDEX, 0);
    drive(0, 1, 1, 0, 0, 0, 32'h8, 32'h0020_0113, 64'h0123_4567_89AB_CDEF);
    expect_next(S_PC, 32'h8); expect_next(S_PCIFID, 32'h4); expect_next(S_INSTR, 32'h0020_0113);
    expect_next(S_VIDEX, 1);  expect_next(S_PCIDEX, 0);     expect_next(S_BUNDLE, 64'h0123_4567_89AB_CDEF);
    drive(0, 1, 1, 0, 0, 0, 32'hC, 32'h0030_0193, 64'hB2);
    expect_next(S_PC, 32'hC); expect_next(S_PCIFID, 32'h8); expect_next(S_PCIDEX, 32'h4);
    drive(0, 1, 1, 0, 0, 0, 32'h10, 32'h0040_0213, 64'hB3);
    expect_next(S_PC, 32'h10); expect_next(S_PCIFID, 32'hC); expect_next(S_PCIDEX, 32'h8);

    // Load-use stall: PC 0x10, IF/ID at 0x0C
    drive(0, 0, 0, 0, 1, 0, 32'h14, 32'h0050_0293, 64'hB4);
    expect_next(S_PC, 32'h10); expect_next(S_PCIFID, 32'hC); expect_next(S_INSTR, 32'h0040_0213);
    expect_next(S_VIDEX, 0);   expect_next(S_BUNDLE, 0);     expect_next(S_STALL, 1);
    expect_next(S_BUBBLE, 1);  expect_next(S_FLUSH, 0);
    // Held instruction advances; counters cleared in the same cycle
    drive(0, 1, 1, 0, 0, 1, 32'h14, 32'h0050_0293, 64'hC3);
    expect_next(S_PC, 32'h14); expect_next(S_PCIFID, 32'h10); expect_next(S_PCIDEX, 32'hC);
    expect_next(S_VIDEX, 1);   expect_next(S_BUNDLE, 64'hC3); expect_next(S_STALL, 0);

    // Taken branch to 0x100
    drive(0, 1, 1, 1, 1, 0, 32'h100, 32'h0060_0313, 64'hC4);
    expect_next(S_PC, 32'h100); expect_next(S_VIFID, 0);  expect_next(S_INSTR, 64'h13);
    expect_next(S_VIDEX, 0);    expect_next(S_FLUSH, 1);  expect_next(S_BUBBLE, 1);
    drive(0, 1, 1, 0, 0, 0, 32'h104, 32'h0070_0393, 64'hC5);
    expect_next(S_PC, 32'h104); expect_next(S_PCIFID, 32'h100); expect_next(S_VIFID, 1);
    expect_next(S_VIDEX, 0);
    drive(0, 1, 1, 0, 0, 0, 32'h108, 32'h0080_0413, 64'hC6);
    expect_next(S_VIDEX, 1); expect_next(S_PCIDEX, 32'h100);

    // Independent enables: IF/ID loads while PC holds
    drive(0, 0, 1, 0, 0, 0, 32'h200, 32'h0090_0493, 64'hC7);
    expect_next(S_PC, 32'h108); expect_next(S_PCIFID, 32'h108); expect_next(S_INSTR, 32'h0090_0493);
    expect_next(S_STALL, 0);
    // Flush wins over hold
    drive(0, 1, 0, 1, 0, 0, 32'h10C, 32'h00A0_0513, 64'hC8);
    expect_next(S_PC, 32'h10C); expect_next(S_VIFID, 0); expect_next(S_INSTR, 64'h13);
    expect_next(S_PCIFID, 0);   expect_next(S_PCIDEX, 32'h108); expect_next(S_VIDEX, 1);
    expect_next(S_FLUSH, 2);    expect_next(S_STALL, 0); expect_next(S_BUBBLE, 1);

    // Back-to-back stalls into saturation
    for (int i = 1; i <= 20; i++) begin
      stall_step();
      if (i == 14) begin
        expect_next(S_STALL, 14); expect_next(S_BUBBLE, 15);
      end
      if (i == 20) begin
        expect_next(S_STALL, 15); expect_next(S_BUBBLE, 15);
        expect_next(S_PC, 32'h10C); expect_next(S_VIFID, 0);
      end
    end
    drive(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 64'h0);
    expect_next(S_STALL, 0); expect_next(S_BUBBLE, 0);
    stall_step();
    expect_next(S_STALL, 1); expect_next(S_BUBBLE, 1);

    // Reset mid-stall at PC 0x40
    drive(0, 1, 1, 0, 0, 0, 32'h40, 32'h00B0_0593, 64'hC9);
    expect_next(S_PC, 32'h40); expect_next(S_PCIFID, 32'h10C); expect_next(S_VIFID, 1);
    stall_step();
    expect_next(S_PC, 32'h40); expect_next(S_STALL, 2);
    drive(1, 0, 0, 0, 1, 0, 32'h44, 32'h00C0_0613, 64'hCA);
    expect_next(S_PC, 0);    expect_next(S_VIFID, 0); expect_next(S_VIDEX, 0);
    expect_next(S_STALL, 0); expect_next(S_INSTR, 64'h13);
    drive(0, 1, 1, 0, 0, 0, 32'h4, 32'h0010_0093, 64'hCB);
    expect_next(S_PC, 32'h4); expect_next(S_VIFID, 1); expect_next(S_PCIFID, 0);

    drive(0, 1, 1, 0, 0, 0, 32'h8, 32'h0, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    applied++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
